// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver: 2-flop input synchronizer, mid-bit sampling FSM and a
// show-ahead receive FIFO with sticky framing and overrun flags.
module uart_rx_fifo #(
   parameter int FIFO_DEPTH = 4
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        rx,
   input  logic [15:0]                 clk_div,
   output logic [7:0]                  m_data,
   output logic                        m_valid,
   input  logic                        m_ready,
   output logic [$clog2(FIFO_DEPTH):0] level,
   output logic                        frame_err,
   output logic                        overrun,
   input  logic                        clr_err,
   output logic                        rx_busy
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] FULL_LVL = (AW+1)'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_BREAK
   } state_t;

   logic          r_rx_meta;
   logic          r_rx_s;
   state_t        r_state;
   logic [15:0]   r_cnt;
   logic [15:0]   r_div_q;
   logic [2:0]    r_bit_idx;
   logic [7:0]    r_shift;
   logic [7:0]    r_mem [FIFO_DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_level;
   logic          r_frame_err;
   logic          r_overrun;

   logic w_half_hit;
   logic w_bit_hit;
   logic w_stop_hit;
   logic w_full;
   logic w_pop;
   logic w_push;
   logic w_ovr_set;
   logic w_ferr_set;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rx_meta <= 1'b1;
         r_rx_s    <= 1'b1;
      end else begin
         r_rx_meta <= rx;
         r_rx_s    <= r_rx_meta;
      end
   end

   assign w_half_hit = (r_cnt == ((r_div_q >> 1) - 16'd1));
   assign w_bit_hit  = (r_cnt == (r_div_q - 16'd1));
   assign w_stop_hit = (r_state == S_STOP) && w_bit_hit;
   assign w_full     = (r_level == FULL_LVL);
   assign w_pop      = m_valid && m_ready;
   assign w_push     = w_stop_hit && r_rx_s && (!w_full || w_pop);
   assign w_ovr_set  = w_stop_hit && r_rx_s && w_full && !w_pop;
   assign w_ferr_set = w_stop_hit && !r_rx_s;

   // div_q is captured at start detect so a clk_div change cannot stretch a frame
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_cnt     <= 16'd0;
         r_div_q   <= 16'd0;
         r_bit_idx <= 3'd0;
         r_shift   <= 8'd0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (!r_rx_s) begin
                  r_state <= S_START;
                  r_cnt   <= 16'd0;
                  r_div_q <= clk_div;
               end
            end
            S_START: begin
               if (w_half_hit) begin
                  r_cnt     <= 16'd0;
                  r_bit_idx <= 3'd0;
                  r_state   <= r_rx_s ? S_IDLE : S_DATA;
               end else begin
                  r_cnt <= r_cnt + 16'd1;
               end
            end
            S_DATA: begin
               if (w_bit_hit) begin
                  r_cnt     <= 16'd0;
                  r_shift   <= {r_rx_s, r_shift[7:1]};
                  r_bit_idx <= r_bit_idx + 3'd1;
                  if (r_bit_idx == 3'd7) begin
                     r_state <= S_STOP;
                  end
               end else begin
                  r_cnt <= r_cnt + 16'd1;
               end
            end
            S_STOP: begin
               if (w_bit_hit) begin
                  r_cnt   <= 16'd0;
                  r_state <= r_rx_s ? S_IDLE : S_BREAK;
               end else begin
                  r_cnt <= r_cnt + 16'd1;
               end
            end
            S_BREAK: begin
               if (r_rx_s) begin
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= r_shift;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_level     <= '0;
         r_frame_err <= 1'b0;
         r_overrun   <= 1'b0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + (AW+1)'(1);
            2'b01:   r_level <= r_level - (AW+1)'(1);
            default: r_level <= r_level;
         endcase
         // a set event in the same cycle as clr_err keeps the flag high
         r_frame_err <= w_ferr_set | (r_frame_err & ~clr_err);
         r_overrun   <= w_ovr_set  | (r_overrun   & ~clr_err);
      end
   end

   assign m_valid   = (r_level != '0);
   assign m_data    = m_valid ? r_mem[r_rd_ptr] : 8'h00;
   assign level     = r_level;
   assign frame_err = r_frame_err;
   assign overrun   = r_overrun;
   assign rx_busy   = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: a table of single-frame receptions plus
// hand-written sequences for glitch, overrun, break, full-FIFO and reset cases.
module tb_uart_rx_fifo;
   logic        clk;
   logic        rst_n;
   logic        rx;
   logic [15:0] clk_div;
   logic [7:0]  m_data;
   logic        m_valid;
   logic        m_ready;
   logic [2:0]  level;
   logic        frame_err;
   logic        overrun;
   logic        clr_err;
   logic        rx_busy;

   int total = 0;
   int bad   = 0;

   uart_rx_fifo #(.FIFO_DEPTH(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .rx        (rx),
      .clk_div   (clk_div),
      .m_data    (m_data),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .level     (level),
      .frame_err (frame_err),
      .overrun   (overrun),
      .clr_err   (clr_err),
      .rx_busy   (rx_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // Monitor: samples 2 time units after each rising edge
   int         cyc = 0;
   int         busy_rise = 0;
   int         valid_rise = 0;
   int         valid_cycles = 0;
   int         busy_cycles = 0;
   logic       prev_busy = 1'b0;
   logic       prev_valid = 1'b0;
   logic [7:0] popq [$];

   initial begin
      forever begin
         @(posedge clk);
         cyc++;
         #2;
         if (rx_busy && !prev_busy) busy_rise = cyc;
         if (m_valid && !prev_valid) valid_rise = cyc;
         if (m_valid) valid_cycles++;
         if (rx_busy) busy_cycles++;
         if (m_valid && m_ready) popq.push_back(m_data);
         prev_busy  = rx_busy;
         prev_valid = m_valid;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end else begin
         $display("ok   %s: %0h", name, act);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Frame ends with rx at the stop-bit value; clk_div is perturbed after the
   // start bit so a receiver that does not latch it would mis-time the frame.
   task automatic send_raw(input logic [7:0] data, input logic [15:0] div, input logic stopv);
      clk_div = div;
      rx = 1'b0;
      tick(int'(div));
      clk_div = div + 16'd3;
      for (int i = 0; i < 8; i++) begin
         rx = data[i];
         tick(int'(div));
      end
      rx = stopv;
      tick(int'(div));
   endtask

   task automatic send(input logic [7:0] data, input logic [15:0] div);
      send_raw(data, div, 1'b1);
      tick(2 * int'(div));
   endtask

   task automatic pop_one();
      m_ready = 1'b1;
      tick(1);
      m_ready = 1'b0;
   endtask

   task automatic clr_pulse();
      clr_err = 1'b1;
      tick(1);
      clr_err = 1'b0;
   endtask

   typedef struct {
      logic [15:0] div;
      logic [7:0]  data;
      logic [7:0]  exp_data;
   } vec_t;

   vec_t vecs [6];

   initial begin
      vecs[0] = '{16'd16, 8'h3D, 8'h3D};
      vecs[1] = '{16'd4,  8'hA5, 8'hA5};
      vecs[2] = '{16'd5,  8'hFF, 8'hFF};
      vecs[3] = '{16'd7,  8'h00, 8'h00};
      vecs[4] = '{16'd32, 8'h81, 8'h81};
      vecs[5] = '{16'd10, 8'h5A, 8'h5A};

      rst_n = 1'b0;
      rx = 1'b1;
      clk_div = 16'd16;
      m_ready = 1'b0;
      clr_err = 1'b0;
      tick(3);
      chk("rst_level", level, 0);
      chk("rst_valid", m_valid, 0);
      chk("rst_data", m_data, 0);
      chk("rst_ferr", frame_err, 0);
      chk("rst_ovr", overrun, 0);
      chk("rst_busy", rx_busy, 0);
      rst_n = 1'b1;
      tick(3);

      for (int v = 0; v < 6; v++) begin
         send(vecs[v].data, vecs[v].div);
         chk($sformatf("vec%0d_data", v), m_data, vecs[v].exp_data);
         chk($sformatf("vec%0d_level", v), level, 1);
         chk($sformatf("vec%0d_valid", v), m_valid, 1);
         chk($sformatf("vec%0d_ferr", v), frame_err, 0);
         pop_one();
         chk($sformatf("vec%0d_level_after_pop", v), level, 0);
      end

      // m_valid rises in the 153rd cycle counting the start-detect cycle as 1
      m_ready = 1'b1;
      popq.delete();
      valid_cycles = 0;
      send(8'h3D, 16'd16);
      chk("timing_popcnt", popq.size(), 1);
      if (popq.size() == 1) chk("timing_byte", popq[0], 8'h3D);
      chk("timing_latency", valid_rise - busy_rise + 1, 153);
      chk("timing_pulse_len", valid_cycles, 1);
      chk("timing_ferr", frame_err, 0);
      chk("timing_ovr", overrun, 0);
      m_ready = 1'b0;

      clk_div = 16'd16;
      busy_cycles = 0;
      rx = 1'b0;
      tick(4);
      rx = 1'b1;
      tick(30);
      chk("glitch_busy_cycles", busy_cycles, 8);
      chk("glitch_busy_now", rx_busy, 0);
      chk("glitch_level", level, 0);
      chk("glitch_ferr", frame_err, 0);
      chk("glitch_ovr", overrun, 0);

      for (int i = 1; i <= 5; i++) send(8'(i), 16'd4);
      chk("ovr_level", level, 4);
      chk("ovr_flag", overrun, 1);
      chk("ovr_ferr", frame_err, 0);
      tick(3);
      chk("ovr_hold_data", m_data, 8'h01);
      for (int i = 1; i <= 4; i++) begin
         chk($sformatf("drain%0d", i), m_data, 8'(i));
         pop_one();
      end
      chk("drain_level", level, 0);
      m_ready = 1'b1;
      tick(2);
      m_ready = 1'b0;
      chk("empty_ready_level", level, 0);
      chk("empty_valid", m_valid, 0);
      clr_pulse();
      chk("clr_ovr", overrun, 0);

      send_raw(8'h55, 16'd16, 1'b0);
      tick(50 * 16);
      chk("brk_ferr", frame_err, 1);
      chk("brk_busy", rx_busy, 1);
      clr_pulse();
      tick(50 * 16);
      chk("brk_single_event", frame_err, 0);
      chk("brk_level", level, 0);
      rx = 1'b1;
      tick(32);
      chk("brk_exit_busy", rx_busy, 0);
      send(8'hA5, 16'd16);
      chk("brk_next_data", m_data, 8'hA5);
      chk("brk_next_level", level, 1);
      chk("brk_next_ferr", frame_err, 0);
      pop_one();

      for (int i = 1; i <= 4; i++) send(8'(i * 16), 16'd4);
      chk("full_level", level, 4);
      popq.delete();
      fork
         send(8'h50, 16'd16);
         begin : pop_at_stop
            int n;
            n = 0;
            while (!rx_busy && n < 400) begin
               tick(1);
               n++;
            end
            if (n >= 400) begin
               chk("full_wait_busy", 0, 1);
            end else begin
               tick(151);
               m_ready = 1'b1;
               tick(1);
               m_ready = 1'b0;
            end
         end
      join
      chk("full_pp_level", level, 4);
      chk("full_pp_ovr", overrun, 0);
      chk("full_pp_popcnt", popq.size(), 1);
      if (popq.size() == 1) chk("full_pp_popped", popq[0], 8'h10);
      for (int i = 2; i <= 5; i++) begin
         chk($sformatf("full_drain%0d", i), m_data, 8'(i * 16));
         pop_one();
      end
      chk("full_drain_level", level, 0);

      for (int i = 1; i <= 5; i++) send(8'(i + 8'h60), 16'd4);
      send_raw(8'h33, 16'd4, 1'b0);
      rx = 1'b1;
      tick(8);
      chk("both_ovr", overrun, 1);
      chk("both_ferr", frame_err, 1);
      chk("both_level", level, 4);
      clr_pulse();
      chk("both_clr_ovr", overrun, 0);
      chk("both_clr_ferr", frame_err, 0);
      chk("both_clr_level", level, 4);

      send_raw(8'h33, 16'd4, 1'b0);
      rx = 1'b1;
      tick(8);
      chk("pre_rst_ferr", frame_err, 1);
      clk_div = 16'd16;
      rx = 1'b0;
      tick(16);
      for (int i = 0; i < 4; i++) begin
         rx = (8'h3D >> i) & 8'h01;
         tick(16);
      end
      rx = (8'h3D >> 4) & 8'h01;
      tick(8);
      chk("mid_busy", rx_busy, 1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_level", level, 0);
      chk("mid_rst_valid", m_valid, 0);
      chk("mid_rst_data", m_data, 0);
      chk("mid_rst_ferr", frame_err, 0);
      chk("mid_rst_ovr", overrun, 0);
      chk("mid_rst_busy", rx_busy, 0);
      rx = 1'b1;
      tick(3);
      rst_n = 1'b1;
      tick(5);
      chk("post_rst_busy", rx_busy, 0);
      send(8'h3D, 16'd16);
      chk("post_rst_data", m_data, 8'h3D);
      chk("post_rst_level", level, 1);
      chk("post_rst_flags", {frame_err, overrun}, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
